// File: rtl/gnrl_pkg.sv
// rtl/gnrl_pkg.sv - shared width helpers and depth limit for the general FIFO
package gnrl_pkg;

    localparam int GNRL_MAX_DP = 256;

    function automatic int gnrl_clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

    // A one-entry FIFO still needs a one-bit pointer signal to be legal.
    function automatic int gnrl_ptr_w(input int dp);
        return (dp > 1) ? gnrl_clog2(dp) : 1;
    endfunction

endpackage

// File: rtl/gnrl_fifo_ptr.sv
// rtl/gnrl_fifo_ptr.sv - pointer counter with enable, wrapping from DP-1 to 0
module gnrl_fifo_ptr
    import gnrl_pkg::*;
#(
    parameter int DP = 4,
    localparam int PW = gnrl_ptr_w(DP)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_en,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] r_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == PW'(DP - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/gnrl_fifo.sv
// rtl/gnrl_fifo.sv - valid/ready FIFO, flop storage; GNRL_FIFO_BYPASS_EN enables empty bypass
module gnrl_fifo
    import gnrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int DP = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        i_vld,
    output logic                        o_rdy,
    input  logic [DW-1:0]               i_dat,
    output logic                        o_vld,
    input  logic                        i_rdy,
    output logic [DW-1:0]               o_dat,
    output logic [gnrl_clog2(DP+1)-1:0] o_cnt,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int PW = gnrl_ptr_w(DP);
    localparam int CW = gnrl_clog2(DP + 1);

    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_mem [DP];
    logic [PW-1:0] w_wptr;
    logic [PW-1:0] w_rptr;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_pass;
    logic          w_wr;
    logic          w_rd;

    assign w_full  = (r_cnt == CW'(DP));
    assign w_empty = (r_cnt == '0);
    assign o_rdy   = !w_full;

`ifdef GNRL_FIFO_BYPASS_EN
    // Empty FIFO forwards the offered word; if it is taken the same cycle, nothing is stored.
    assign o_vld  = !w_empty || i_vld;
    assign o_dat  = w_empty ? i_dat : r_mem[w_rptr];
    assign w_pass = w_empty && i_vld && i_rdy;
`else
    assign o_vld  = !w_empty;
    assign o_dat  = r_mem[w_rptr];
    assign w_pass = 1'b0;
`endif

    assign w_push = i_vld && o_rdy;
    assign w_pop  = o_vld && i_rdy;
    assign w_wr   = w_push && !w_pass;
    assign w_rd   = w_pop && !w_pass;

    gnrl_fifo_ptr #(.DP(DP)) u_wptr (
        .clk   (clk),
        .rstn  (rstn),
        .i_en  (w_wr),
        .o_ptr (w_wptr)
    );

    gnrl_fifo_ptr #(.DP(DP)) u_rptr (
        .clk   (clk),
        .rstn  (rstn),
        .i_en  (w_rd),
        .o_ptr (w_rptr)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage is deliberately left out of reset; o_vld gates its visibility.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DP; i++) begin
            if (w_wr && (w_wptr == PW'(i))) r_mem[i] <= i_dat;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: tb/tb_gnrl_fifo.sv
// tb/tb_gnrl_fifo.sv - self-checking bench for gnrl_fifo (DP=4 and DP=3 instances)
module tb_gnrl_fifo;

    localparam int DW = 8;
`ifdef GNRL_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          r;
        int          cnt;
        bit          full;
        bit          empty;
        logic [7:0]  head;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;

    logic a_ivld, a_irdy, a_ordy, a_ovld, a_full, a_empty;
    logic [DW-1:0] a_idat, a_odat;
    logic [2:0] a_cnt;
    logic b_ivld, b_irdy, b_ordy, b_ovld, b_full, b_empty;
    logic [DW-1:0] b_idat, b_odat;
    logic [1:0] b_cnt;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    vec_t tbl[16];

    always #5 clk = ~clk;

    gnrl_fifo #(.DW(DW), .DP(4)) u_dut_a (
        .clk(clk), .rstn(rstn), .i_vld(a_ivld), .o_rdy(a_ordy), .i_dat(a_idat),
        .o_vld(a_ovld), .i_rdy(a_irdy), .o_dat(a_odat), .o_cnt(a_cnt),
        .o_full(a_full), .o_empty(a_empty)
    );

    gnrl_fifo #(.DW(DW), .DP(3)) u_dut_b (
        .clk(clk), .rstn(rstn), .i_vld(b_ivld), .o_rdy(b_ordy), .i_dat(b_idat),
        .o_vld(b_ovld), .i_rdy(b_irdy), .o_dat(b_odat), .o_cnt(b_cnt),
        .o_full(b_full), .o_empty(b_empty)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Checks the flags and counters of instance k against an occupancy/head pair.
    task automatic check_state(input int k, input string tag, input int sz, input int dp,
                               input bit ev, input logic [7:0] ed);
        if (k == 0) begin
            check({tag, "_a_cnt"}, int'(a_cnt), sz);
            check({tag, "_a_full"}, int'(a_full), int'(sz == dp));
            check({tag, "_a_empty"}, int'(a_empty), int'(sz == 0));
            check({tag, "_a_rdy"}, int'(a_ordy), int'(sz < dp));
            check({tag, "_a_vld"}, int'(a_ovld), int'(ev));
            if (ev) check({tag, "_a_dat"}, int'(a_odat), int'(ed));
        end else begin
            check({tag, "_b_cnt"}, int'(b_cnt), sz);
            check({tag, "_b_full"}, int'(b_full), int'(sz == dp));
            check({tag, "_b_empty"}, int'(b_empty), int'(sz == 0));
            check({tag, "_b_rdy"}, int'(b_ordy), int'(sz < dp));
            check({tag, "_b_vld"}, int'(b_ovld), int'(ev));
            if (ev) check({tag, "_b_dat"}, int'(b_odat), int'(ed));
        end
    endtask

    // One clock of traffic on instance k: drive at negedge, compare against the queue model,
    // then advance the model by what the next rising edge must do.
    task automatic cycle(input int k, input bit v, input logic [7:0] d, input bit r);
        int sz, dp;
        bit ev, push, pop;
        logic [7:0] ed;
        @(negedge clk);
        if (k == 0) begin
            a_ivld = v; a_idat = d; a_irdy = r;
            b_ivld = 1'b0; b_irdy = 1'b0;
            sz = qa.size(); dp = 4;
            ed = (sz > 0) ? qa[0] : d;
        end else begin
            b_ivld = v; b_idat = d; b_irdy = r;
            a_ivld = 1'b0; a_irdy = 1'b0;
            sz = qb.size(); dp = 3;
            ed = (sz > 0) ? qb[0] : d;
        end
        #1;
        ev = (sz > 0) || (BYP && v);
        check_state(k, "cyc", sz, dp, ev, ed);
        push = v && (sz < dp);
        pop  = ev && r;
        if (!(sz == 0 && push && pop)) begin
            if (k == 0) begin
                if (pop) void'(qa.pop_front());
                if (push) qa.push_back(d);
            end else begin
                if (pop) void'(qb.pop_front());
                if (push) qb.push_back(d);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        a_ivld = 1'b0; a_irdy = 1'b0; a_idat = '0;
        b_ivld = 1'b0; b_irdy = 1'b0; b_idat = '0;
        #2;
        check_state(0, "rst", 0, 4, 1'b0, 8'h00);
        check_state(1, "rst", 0, 3, 1'b0, 8'h00);
        @(negedge clk);
        rstn = 1'b1;

        // Fill/drain, full-refusal of 0xBB, drain to empty.
        tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1, 1'b0, 1'b0, 8'hA1};
        tbl[1]  = '{1'b1, 8'hA2, 1'b0, 2, 1'b0, 1'b0, 8'hA1};
        tbl[2]  = '{1'b1, 8'hA3, 1'b0, 3, 1'b0, 1'b0, 8'hA1};
        tbl[3]  = '{1'b1, 8'hA4, 1'b0, 4, 1'b1, 1'b0, 8'hA1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0, 8'hA2};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 8'hA3};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'hA4};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h00};
        tbl[8]  = '{1'b1, 8'hC1, 1'b0, 1, 1'b0, 1'b0, 8'hC1};
        tbl[9]  = '{1'b1, 8'hC2, 1'b0, 2, 1'b0, 1'b0, 8'hC1};
        tbl[10] = '{1'b1, 8'hC3, 1'b0, 3, 1'b0, 1'b0, 8'hC1};
        tbl[11] = '{1'b1, 8'hC4, 1'b0, 4, 1'b1, 1'b0, 8'hC1};
        tbl[12] = '{1'b1, 8'hBB, 1'b1, 3, 1'b0, 1'b0, 8'hC2};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 8'hC3};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'hC4};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h00};
        foreach (tbl[i]) begin
            cycle(0, tbl[i].v, tbl[i].d, tbl[i].r);
            @(posedge clk);
            #1;
            check_state(0, "tbl", tbl[i].cnt, 4,
                        (tbl[i].cnt > 0) || (BYP && tbl[i].v), tbl[i].head);
        end

        // Half-full steady push+pop across pointer wrap.
        cycle(0, 1'b1, 8'h30, 1'b0);
        cycle(0, 1'b1, 8'h31, 1'b0);
        for (int i = 0; i < 10; i++) cycle(0, 1'b1, 8'h32 + 8'(i), 1'b1);
        cycle(0, 1'b0, 8'h00, 1'b1);
        cycle(0, 1'b0, 8'h00, 1'b1);
        cycle(0, 1'b0, 8'h00, 1'b0);

        // Push into an empty FIFO with the reader ready.
        cycle(0, 1'b1, 8'h55, 1'b1);
        cycle(0, 1'b0, 8'h00, 1'b1);
        cycle(0, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 3; i++) cycle(0, 1'b1, 8'h60 + 8'(i), 1'b0);
        cycle(0, 1'b0, 8'h00, 1'b0);
        #1;
        rstn = 1'b0;
        #1;
        qa.delete();
        qb.delete();
        check_state(0, "arst", 0, 4, 1'b0, 8'h00);
        @(negedge clk);
        rstn = 1'b1;
        cycle(0, 1'b1, 8'h77, 1'b0);
        cycle(0, 1'b0, 8'h00, 1'b1);
        cycle(0, 1'b0, 8'h00, 1'b0);

        // DP=3: fill, refused push when full, then 7 push/pop pairs wrapping.
        for (int i = 0; i < 3; i++) cycle(1, 1'b1, 8'hE0 + 8'(i), 1'b0);
        cycle(1, 1'b1, 8'hE3, 1'b0);
        cycle(1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1, 1'b1, 8'hF0 + 8'(i), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1, 1'b0, 8'h00, 1'b1);
        cycle(1, 1'b0, 8'h00, 1'b0);

        // Random traffic on both instances.
        for (int i = 0; i < 800; i++) begin
            cycle(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom), 1'($urandom_range(0, 1)));
        end
        cycle(0, 1'b0, 8'h00, 1'b0);
        cycle(1, 1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gnrl_fifo.md
GNRL_FIFO -- requirements
Module: gnrl_fifo

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits.
REQ-002 SHALL have parameter DP, default 4, depth in entries (legal range 1..256).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_vld  input  1  writer offers data.
REQ-006 SHALL have port o_rdy  output  1  FIFO accepts data.
REQ-007 SHALL have port i_dat  input  DW  write data.
REQ-008 SHALL have port o_vld  output  1  FIFO presents data to reader.
REQ-009 SHALL have port i_rdy  input  1  reader accepts data.
REQ-010 SHALL have port o_dat  output  DW  read data (head entry).
REQ-011 SHALL have port o_cnt  output  clog2(DP+1)  current occupancy.
REQ-012 SHALL have ports o_full and o_empty  output  1 each  occupancy flags.

Function
REQ-013 Push SHALL occur in a cycle where i_vld=1 and o_rdy=1; pop SHALL occur where o_vld=1 and i_rdy=1.
REQ-014 o_rdy SHALL equal !o_full; o_vld SHALL equal !o_empty (bypass case per REQ-026).
REQ-015 Pushed data SHALL appear on o_dat with o_vld=1 one cycle after the push edge when FIFO was empty.
REQ-016 o_dat SHALL be a combinational read of the entry at the read pointer; no output register.
REQ-017 Data SHALL leave in push order; no loss, no duplication.
REQ-018 Write and read pointers SHALL increment by one per push/pop and wrap from DP-1 to 0 (DP need not be a power of two).
REQ-019 o_cnt SHALL be +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop or idle.
REQ-020 o_full SHALL be 1 iff o_cnt==DP; o_empty SHALL be 1 iff o_cnt==0; all three registered-state derived, no glitch from i_* inputs.
REQ-021 Full with i_vld=1 and i_rdy=1: pop SHALL occur, push SHALL be refused (o_rdy=0 that cycle); o_cnt becomes DP-1.
REQ-022 Empty with i_rdy=1 and no bypass: no pop, pointers and o_cnt unchanged.
REQ-023 i_vld or i_rdy while the other side stalls SHALL not alter stored data; writer and reader handshakes are independent.

Reset
REQ-024 On rstn=0 pointers and o_cnt SHALL clear to 0 immediately: o_empty=1, o_full=0, o_vld=0, o_rdy=1 (o_rdy=0 when DP==0 is illegal).
REQ-025 Storage entries SHALL not be reset; o_dat is don't-care while o_vld=0; reset mid-operation discards all contents.

Configuration
REQ-026 With GNRL_FIFO_BYPASS_EN defined: when empty and i_vld=1, o_vld SHALL be 1 and o_dat SHALL equal i_dat same cycle; if i_rdy=1 the word passes through with no write and o_cnt stays 0; if i_rdy=0 the word is written normally.
REQ-027 Without GNRL_FIFO_BYPASS_EN: no combinational path from i_vld/i_dat to o_vld/o_dat; minimum latency one cycle per REQ-015.

Structure
REQ-028 Shared package gnrl_pkg SHALL hold the pointer/count width function (clog2) and the depth limit constant; no FIFO-local typedefs.
REQ-029 One sub-module gnrl_fifo_ptr SHALL implement a wrap-at-DP pointer counter with enable, instantiated for write and read pointers.
REQ-030 Storage SHALL be a DP x DW flop array written with per-entry load enable; all sequential logic asynchronous-reset per REQ-024.

Verification
REQ-031 DP=4: push 0xA1,0xA2,0xA3,0xA4, i_rdy=0 -> o_full=1, o_rdy=0, o_cnt=4; then i_rdy=1 four cycles -> o_dat 0xA1..0xA4 in order, o_empty=1.
REQ-032 Full, i_vld=1 i_dat=0xBB, i_rdy=1 -> one pop, 0xBB not stored, o_cnt=3.
REQ-033 Half-full (2), continuous push+pop 10 cycles with incrementing data -> o_cnt stays 2, pointers wrap, order preserved.
REQ-034 Empty, i_vld=1 i_dat=0x55, i_rdy=1: bypass build -> o_vld=1, o_dat=0x55 same cycle, o_cnt=0; non-bypass -> o_vld=0, next cycle o_dat=0x55.
REQ-035 o_cnt=3, assert rstn=0 between edges -> o_cnt=0, o_empty=1, o_vld=0 immediately; after release, first push reads back correctly.
REQ-036 DP=3 (non-power-of-two): 7 push/pop pairs with wrap -> data order correct, o_full at exactly 3.
